// File: rtl/key_cond_pkg.sv
// Shared types and default constants for the pushbutton conditioner.
// Holds the per-channel state encoding and the 50 MHz / short-sim defaults.
package key_cond_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    DISARMING = 2'd3
  } key_state_t;

  // 50 MHz board values: 10 ms debounce, 0.5 s first repeat, 0.1 s period
  localparam int DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int DEF_CNT_W           = 20;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_PERIOD   = 5_000_000;

  // Short values for fast simulation
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam int SIM_CNT_W           = 3;
  localparam int SIM_REPEAT_DELAY    = 10;
  localparam int SIM_REPEAT_PERIOD   = 3;

endpackage

// File: rtl/key_debounce_channel.sv
// One key: 2-flop sync, debounce FSM, optional auto-repeat (KEY_AUTOREPEAT_EN).
// Ports: clk, rst_n (async low), key_raw (active-low pin) -> level/press/release/repeat pulses.
module key_debounce_channel
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
`ifdef KEY_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync;
  logic             s;
  key_state_t       state;
  logic [CNT_W-1:0] cnt;

  // Flops reset to 1 so a released key looks released out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], key_raw};
  end

  assign s = ~sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RELEASED;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (s) begin
            state <= ARMING;
            cnt   <= CNT_ONE;
          end
        end
        ARMING: begin
          if (!s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state       <= PRESSED;
            cnt         <= '0;
            level       <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s) begin
            state <= DISARMING;
            cnt   <= CNT_ONE;
          end
        end
        DISARMING: begin
          if (s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state         <= RELEASED;
            cnt           <= '0;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                        REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;
  logic          first;
  logic          held;
  logic          leaving;

  assign held    = (state == PRESSED) || (state == DISARMING);
  // An accepted release wins over a repeat due on the same edge
  assign leaving = (state == DISARMING) && !s && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt         <= '0;
      first        <= 1'b1;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (!held || leaving) begin
        rcnt  <= '0;
        first <= 1'b1;
      end else if (rcnt == (first ? R_FIRST : R_NEXT)) begin
        rcnt         <= '0;
        first        <= 1'b0;
        repeat_pulse <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Conditions NUM_KEYS active-low pushbuttons into clean level + press/release strobes.
// Ports: CLOCK_50, KEY0 (async low reset), key_n in; key_level/press/release/repeat out (KEY_AUTOREPEAT_EN).
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                CLOCK_50,
  input  logic                KEY0,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_repeat
);

  // Counter must hold DEBOUNCE_CYCLES without wrapping
  if (((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) ||
      (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_cfg
    $error("key_conditioner: bad parameter set");
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
`ifdef KEY_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk          (CLOCK_50),
      .rst_n        (KEY0),
      .key_raw      (key_n[i]),
      .level        (key_level[i]),
      .press_pulse  (key_press[i]),
      .release_pulse(key_release[i]),
      .repeat_pulse (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with short debounce/repeat settings.
// Stimulus queues expected strobes by cycle; a negedge monitor pops and compares.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key_n;
  logic [1:0] key_level, key_press, key_release, key_repeat;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [1:0] p;
    logic [1:0] r;
    logic [1:0] t;
  } ev_t;

  ev_t q[$];

  key_conditioner #(
    .NUM_KEYS       (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .CLOCK_50   (clk),
    .KEY0       (rst_n),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected strobes kept sorted by cycle; same-cycle entries merge
  function automatic void push(int c, logic [1:0] p,
                               logic [1:0] r, logic [1:0] t);
    ev_t e;
    int  i = 0;
    while (i < q.size() && q[i].cyc < c) i++;
    if (i < q.size() && q[i].cyc == c) begin
      e   = q[i];
      e.p = e.p | p;
      e.r = e.r | r;
      e.t = e.t | t;
      q[i] = e;
    end else begin
      e.cyc = c;
      e.p   = p;
      e.r   = r;
      e.t   = t;
      q.insert(i, e);
    end
  endfunction

  task automatic at(int n);
    while (cyc < n - 1) @(negedge clk);
  endtask

  task automatic chk_lvl(int n, logic [1:0] exp, string nm);
    while (cyc < n) @(negedge clk);
    checks++;
    if (key_level !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: key_level got %b want %b",
               nm, cyc, key_level, exp);
    end
  endtask

  task automatic chk_zero(string nm);
    logic [7:0] got;
    got = {key_level, key_press, key_release, key_repeat};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL %s cyc=%0d: outputs got %b want 00000000",
               nm, cyc, got);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_strobe: no strobe at cyc %0d, want p=%b r=%b t=%b",
                 q[0].cyc, q[0].p, q[0].r, q[0].t);
        void'(q.pop_front());
      end
      if (|{key_press, key_release, key_repeat}) begin
        checks++;
        if (q.size() == 0 || q[0].cyc != cyc) begin
          errors++;
          $display("FAIL unexpected_strobe cyc=%0d: got p=%b r=%b t=%b want none",
                   cyc, key_press, key_release, key_repeat);
        end else begin
          ev_t e;
          e = q.pop_front();
          if ({key_press, key_release, key_repeat} !== {e.p, e.r, e.t}) begin
            errors++;
            $display("FAIL strobe cyc=%0d: got p=%b r=%b t=%b want p=%b r=%b t=%b",
                     cyc, key_press, key_release, key_repeat, e.p, e.r, e.t);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    key_n = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset_state");
    at(3);
    rst_n = 1'b1;

    // Clean press on key 0, held long enough to auto-repeat
    at(10);
    key_n = 2'b10;
    push(16, 2'b01, 2'b00, 2'b00);
`ifdef KEY_AUTOREPEAT_EN
    for (int c = 26; c < 41; c += 3) push(c, 2'b00, 2'b00, 2'b01);
`endif
    chk_lvl(15, 2'b00, "arming_level");
    chk_lvl(16, 2'b01, "press_level");
    at(35);
    key_n = 2'b11;
    push(41, 2'b00, 2'b01, 2'b00);
    chk_lvl(40, 2'b01, "disarming_level");
    chk_lvl(41, 2'b00, "release_level");

    // Bounce while arming restarts the count
    at(50);
    key_n = 2'b10;
    at(53);
    key_n = 2'b11;
    at(54);
    key_n = 2'b10;
    push(60, 2'b01, 2'b00, 2'b00);
    chk_lvl(59, 2'b00, "bounce_level");
    chk_lvl(60, 2'b01, "bounce_press_level");

    // Release with a 2-cycle low glitch during disarming
    at(62);
    key_n = 2'b11;
    at(66);
    key_n = 2'b10;
    at(68);
    key_n = 2'b11;
    push(74, 2'b00, 2'b01, 2'b00);
`ifdef KEY_AUTOREPEAT_EN
    push(70, 2'b00, 2'b00, 2'b01);
    push(73, 2'b00, 2'b00, 2'b01);
`endif
    chk_lvl(73, 2'b01, "glitch_level");
    chk_lvl(74, 2'b00, "glitch_release_level");

    // Reset while key 1 is pressed and key 0 is arming
    at(80);
    key_n = 2'b01;
    push(86, 2'b10, 2'b00, 2'b00);
    at(90);
    key_n = 2'b00;
    chk_lvl(92, 2'b10, "pre_reset_level");
    at(94);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    at(97);
    rst_n = 1'b1;
    push(103, 2'b11, 2'b00, 2'b00);
    chk_lvl(102, 2'b00, "post_reset_arming");
    chk_lvl(103, 2'b11, "post_reset_press");
    at(106);
    key_n = 2'b11;
    push(112, 2'b00, 2'b11, 2'b00);
    chk_lvl(112, 2'b00, "post_reset_release");

    // Simultaneous press, then release key 1 only
    at(130);
    key_n = 2'b00;
    push(136, 2'b11, 2'b00, 2'b00);
    chk_lvl(136, 2'b11, "simul_press_level");
    at(138);
    key_n = 2'b10;
    push(144, 2'b00, 2'b10, 2'b00);
    chk_lvl(144, 2'b01, "key1_release_level");
    at(150);
    key_n = 2'b11;
    push(156, 2'b00, 2'b01, 2'b00);
`ifdef KEY_AUTOREPEAT_EN
    for (int c = 146; c < 156; c += 3) push(c, 2'b00, 2'b00, 2'b01);
`endif
    chk_lvl(156, 2'b00, "key0_release_level");

    while (cyc < 170) @(negedge clk);
    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL pending_strobe: no strobe at cyc %0d, want p=%b r=%b t=%b",
               q[0].cyc, q[0].p, q[0].r, q[0].t);
      void'(q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
